// File: rtl/pc_sched_pkg.sv
// Shared constants, tid width helper and scheduler state encoding for pc_thread_scheduler.
package pc_sched_pkg;

    localparam int NUM_THREADS_DEF = 4;
    localparam int PC_W_DEF        = 64;

    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TID_W_DEF = tid_width(NUM_THREADS_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/pc_thread_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int TID_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [TID_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [TID_W-1:0] grant_tid,
    output logic             any_grant
);

    // Scan from the farthest candidate back to ptr so the nearest requester wins last.
    always_comb begin
        logic [TID_W-1:0] idx_v;
        grant_tid = {TID_W{1'b0}};
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_v     = TID_W'((int'(ptr) + k) % N);
            grant_tid = req[idx_v] ? idx_v : grant_tid;
            any_grant = any_grant | req[idx_v];
        end
        grant = any_grant ? (N'(1'b1) << grant_tid) : {N{1'b0}};
    end

endmodule

// File: rtl/pc_thread_scheduler.sv
// Multi-thread PC scheduler: round-robin fetch offers with redirect/flush.
// Optional macro PC_SCHED_PERF_EN adds a saturating 32-bit issue counter output.
module pc_thread_scheduler
    import pc_sched_pkg::*;
#(
    parameter int               NUM_THREADS = NUM_THREADS_DEF,
    parameter int               PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC    = {PC_W{1'b0}},
    localparam int              TID_W       = tid_width(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic [NUM_THREADS-1:0] stall,
    input  logic                   br_valid,
    input  logic [TID_W-1:0]       br_tid,
    input  logic [PC_W-1:0]        br_target,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [PC_W-1:0]        fetch_pc,
    output logic [TID_W-1:0]       fetch_tid
`ifdef PC_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_issue_cnt
`endif
);

    sched_state_t           state_r;
    logic                   started_r;
    logic [TID_W-1:0]       rr_ptr_r;
    logic [PC_W-1:0]        pc_r      [NUM_THREADS];
    logic [PC_W-1:0]        pc_next_s [NUM_THREADS];
    logic [PC_W-1:0]        grant_pc_s;
    logic [NUM_THREADS-1:0] eligible_s;
    logic [NUM_THREADS-1:0] grant_s;
    logic [TID_W-1:0]       grant_tid_s;
    logic [TID_W-1:0]       arb_ptr_s;
    logic [TID_W-1:0]       ptr_after_s;
    logic                   any_grant_s;
    logic                   flush_s;
    logic                   issue_s;

    assign eligible_s  = thread_en & ~stall;
    assign flush_s     = br_valid & fetch_valid & (br_tid == fetch_tid);
    assign issue_s     = fetch_valid & fetch_ready & ~flush_s;
    assign ptr_after_s = (fetch_tid == TID_W'(NUM_THREADS - 1)) ? {TID_W{1'b0}}
                                                                 : fetch_tid + TID_W'(1'b1);
    // After an issue the search restarts just past the issued thread.
    assign arb_ptr_s   = issue_s ? ptr_after_s : rr_ptr_r;

    rr_arbiter #(
        .N     (NUM_THREADS),
        .TID_W (TID_W)
    ) u_arb (
        .req       (eligible_s),
        .ptr       (arb_ptr_s),
        .grant     (grant_s),
        .grant_tid (grant_tid_s),
        .any_grant (any_grant_s)
    );

    // Next PC per thread (redirect beats increment) and the PC of the newly granted thread.
    always_comb begin
        grant_pc_s = {PC_W{1'b0}};
        for (int i = 0; i < NUM_THREADS; i++) begin
            pc_next_s[i] = (br_valid && (br_tid == TID_W'(i))) ? br_target :
                           (issue_s && (fetch_tid == TID_W'(i))) ? pc_r[i] + PC_W'(1'b1) :
                           pc_r[i];
            grant_pc_s   = grant_pc_s | (pc_next_s[i] & {PC_W{grant_s[i]}});
        end
    end

    // Per-thread PC storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_r[i] <= RESET_PC;
            end
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Offer FSM; started_r holds off the first offer until one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            started_r   <= 1'b0;
            rr_ptr_r    <= {TID_W{1'b0}};
            fetch_valid <= 1'b0;
            fetch_pc    <= RESET_PC;
            fetch_tid   <= {TID_W{1'b0}};
        end else begin
            started_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (started_r && any_grant_s) begin
                        state_r     <= OFFER;
                        fetch_valid <= 1'b1;
                        fetch_tid   <= grant_tid_s;
                        fetch_pc    <= grant_pc_s;
                    end else begin
                        fetch_valid <= 1'b0;
                    end
                end
                OFFER: begin
                    if (flush_s) begin
                        state_r     <= IDLE;
                        fetch_valid <= 1'b0;
                    end else if (issue_s) begin
                        rr_ptr_r <= ptr_after_s;
                        if (any_grant_s) begin
                            fetch_valid <= 1'b1;
                            fetch_tid   <= grant_tid_s;
                            fetch_pc    <= grant_pc_s;
                        end else begin
                            state_r     <= IDLE;
                            fetch_valid <= 1'b0;
                        end
                    end else begin
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SCHED_PERF_EN
    // Saturating issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= 32'h0000_0000;
        end else if (issue_s && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
            perf_issue_cnt <= perf_issue_cnt + 32'h0000_0001;
        end else begin
            perf_issue_cnt <= perf_issue_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pc_thread_scheduler.sv
// Self-checking bench for pc_thread_scheduler: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_thread_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  thread_en;
    logic [3:0]  stall;
    logic        br_valid;
    logic [1:0]  br_tid;
    logic [63:0] br_target;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_pc;
    logic [1:0]  fetch_tid;
`ifdef PC_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_pc [4];
    int          m_ptr;
    bit          m_valid;
    int          m_tid;
    logic [63:0] m_fpc;
    bit          m_started;
    int unsigned m_cnt;

    pc_thread_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .thread_en   (thread_en),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_tid      (br_tid),
        .br_target   (br_target),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_tid   (fetch_tid)
`ifdef PC_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pc[i] = 64'd0;
        m_ptr = 0; m_valid = 0; m_tid = 0; m_fpc = 64'd0; m_started = 0; m_cnt = 0;
    endtask

    // One clock of the scheduling rules, applied to the inputs seen at this edge.
    task automatic model_step();
        logic [63:0] npc [4];
        bit issue, flush;
        int sel, p;
        if (!rst_n) begin
            model_reset();
            return;
        end
        flush = m_valid && br_valid && (int'(br_tid) == m_tid);
        issue = m_valid && fetch_ready && !flush;
        npc = m_pc;
        if (issue) begin
            npc[m_tid] = m_pc[m_tid] + 64'd1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            m_ptr = (m_tid + 1) % 4;
        end
        if (br_valid) npc[br_tid] = br_target;
        sel = -1;
        for (int k = 0; k < 4; k++) begin
            p = (m_ptr + k) % 4;
            if (sel < 0 && thread_en[p] && !stall[p]) sel = p;
        end
        if (flush) begin
            m_valid = 0;
        end else if (m_valid && !issue) begin
            m_valid = 1;
        end else if (m_started && sel >= 0) begin
            m_valid = 1; m_tid = sel; m_fpc = npc[sel];
        end else begin
            m_valid = 0;
        end
        m_pc = npc;
        m_started = 1;
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        thread_en = 4'b0000; stall = 4'b0000; br_valid = 1'b0; br_tid = 2'd0;
        br_target = 64'd0; fetch_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", fetch_valid); end
        checks++; if (fetch_tid !== 2'd0) begin errors++; $display("FAIL reset_tid: got %0d want 0", fetch_tid); end
        checks++; if (fetch_pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", fetch_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        thread_en = 4'b1111;
        do_cycle();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL first_edge_no_offer: got %0b want 0", fetch_valid); end
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0) begin
            errors++; $display("FAIL first_offer: got v=%0b tid=%0d want v=1 tid=0", fetch_valid, fetch_tid);
        end
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_pc;
        apply_reset();
        thread_en = 4'b1111; fetch_ready = 1'b1;
        do_cycle();
        for (int k = 0; k < 5; k++) begin
            do_cycle();
            exp_pc = (k == 4) ? 64'd1 : 64'd0;
            checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'(k % 4) || fetch_pc !== exp_pc) begin
                errors++; $display("FAIL rr_%0d: got v=%0b tid=%0d pc=%0h want v=1 tid=%0d pc=%0h",
                                   k, fetch_valid, fetch_tid, fetch_pc, k % 4, exp_pc);
            end
        end
    endtask

    task automatic test_masked();
        logic [1:0]  exp_tid [4];
        logic [63:0] exp_pc  [4];
        exp_tid = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_pc  = '{64'd0, 64'd0, 64'd1, 64'd1};
        apply_reset();
        thread_en = 4'b0101; fetch_ready = 1'b1;
        do_cycle();
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            checks++; if (fetch_valid !== 1'b1 || fetch_tid !== exp_tid[k] || fetch_pc !== exp_pc[k]) begin
                errors++; $display("FAIL masked_%0d: got tid=%0d pc=%0h want tid=%0d pc=%0h",
                                   k, fetch_tid, fetch_pc, exp_tid[k], exp_pc[k]);
            end
        end
        thread_en = 4'b1010;
        do_cycle();
        checks++; if (fetch_tid !== 2'd3 || fetch_pc !== 64'd0) begin
            errors++; $display("FAIL masked_t3: got tid=%0d pc=%0h want tid=3 pc=0", fetch_tid, fetch_pc);
        end
        do_cycle();
        checks++; if (fetch_tid !== 2'd1 || fetch_pc !== 64'd0) begin
            errors++; $display("FAIL masked_t1: got tid=%0d pc=%0h want tid=1 pc=0", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        thread_en = 4'b0010; br_valid = 1'b1; br_tid = 2'd1; br_target = 64'd5;
        do_cycle();
        br_valid = 1'b0;
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 64'd5) begin
            errors++; $display("FAIL hold_offer: got v=%0b tid=%0d pc=%0h want v=1 tid=1 pc=5", fetch_valid, fetch_tid, fetch_pc);
        end
        stall = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 64'd5) begin
                errors++; $display("FAIL hold_%0d: got v=%0b tid=%0d pc=%0h want v=1 tid=1 pc=5", k, fetch_valid, fetch_tid, fetch_pc);
            end
        end
        fetch_ready = 1'b1;
        do_cycle();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL hold_stalled_idle: got v=%0b want 0", fetch_valid); end
        stall = 4'b0000; fetch_ready = 1'b0;
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 64'd6) begin
            errors++; $display("FAIL hold_incr: got v=%0b tid=%0d pc=%0h want v=1 tid=1 pc=6", fetch_valid, fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        thread_en = 4'b0100;
        do_cycle();
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd2 || fetch_pc !== 64'd0) begin
            errors++; $display("FAIL flush_pre: got v=%0b tid=%0d pc=%0h want v=1 tid=2 pc=0", fetch_valid, fetch_tid, fetch_pc);
        end
        fetch_ready = 1'b1; br_valid = 1'b1; br_tid = 2'd2; br_target = 64'h100;
        do_cycle();
        br_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got v=%0b want 0", fetch_valid); end
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd2 || fetch_pc !== 64'h100) begin
            errors++; $display("FAIL flush_reoffer: got v=%0b tid=%0d pc=%0h want v=1 tid=2 pc=100", fetch_valid, fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        thread_en = 4'b0001; br_valid = 1'b1; br_tid = 2'd0; br_target = 64'hFFFF_FFFF_FFFF_FFFF;
        do_cycle();
        br_valid = 1'b0;
        do_cycle();
        checks++; if (fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_pre: got pc=%0h want all-ones", fetch_pc); end
        fetch_ready = 1'b1;
        do_cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 || fetch_pc !== 64'd0) begin
            errors++; $display("FAIL wrap_zero: got v=%0b tid=%0d pc=%0h want v=1 tid=0 pc=0", fetch_valid, fetch_tid, fetch_pc);
        end
`ifdef PC_SCHED_PERF_EN
        do_cycle();
        do_cycle();
        checks++; if (perf_issue_cnt !== 32'd3) begin errors++; $display("FAIL perf_wrap: got %0d want 3", perf_issue_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        thread_en = 4'b1111; fetch_ready = 1'b1;
        for (int k = 0; k < 6; k++) do_cycle();
        fetch_ready = 1'b0;
        do_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0 || fetch_tid !== 2'd0 || fetch_pc !== 64'd0) begin
            errors++; $display("FAIL async_reset: got v=%0b tid=%0d pc=%0h want v=0 tid=0 pc=0", fetch_valid, fetch_tid, fetch_pc);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        do_cycle();
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'(k) || fetch_pc !== 64'd0) begin
                errors++; $display("FAIL restart_%0d: got v=%0b tid=%0d pc=%0h want v=1 tid=%0d pc=0", k, fetch_valid, fetch_tid, fetch_pc, k);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            thread_en   = 4'($urandom);
            stall       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            fetch_ready = ($urandom_range(0, 3) != 0);
            br_valid    = ($urandom_range(0, 4) == 0);
            br_tid      = 2'($urandom);
            br_target   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {32'($urandom), 32'($urandom)};
            do_cycle();
            checks++; if (fetch_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid_%0d: got %0b want %0b", n, fetch_valid, m_valid);
            end
            if (m_valid) begin
                checks++; if (fetch_tid !== 2'(m_tid) || fetch_pc !== m_fpc) begin
                    errors++; $display("FAIL rand_offer_%0d: got tid=%0d pc=%0h want tid=%0d pc=%0h", n, fetch_tid, fetch_pc, m_tid, m_fpc);
                end
            end
`ifdef PC_SCHED_PERF_EN
            checks++; if (perf_issue_cnt !== m_cnt) begin
                errors++; $display("FAIL rand_perf_%0d: got %0d want %0d", n, perf_issue_cnt, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_masked();
        test_hold();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_thread_scheduler.md
PC_THREAD_SCHEDULER -- requirements
Module: pc_thread_scheduler

Interface
REQ-001 Parameter NUM_THREADS, default 4, number of hardware threads; each thread owns one PC.
REQ-002 Parameter PC_W, default 64, PC width in bits.
REQ-003 Parameter RESET_PC, default 0, value every thread PC takes at reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 thread_en  input  NUM_THREADS  per-thread enable; thread eligible only while set.
REQ-007 stall  input  NUM_THREADS  per-thread stall; stalled thread is not selected.
REQ-008 br_valid  input  1  redirect request this cycle.
REQ-009 br_tid  input  log2(NUM_THREADS)  thread being redirected.
REQ-010 br_target  input  PC_W  new PC for br_tid.
REQ-011 fetch_valid  output  1  fetch offer present.
REQ-012 fetch_ready  input  1  consumer accepts the offer.
REQ-013 fetch_pc  output  PC_W  PC of offered thread.
REQ-014 fetch_tid  output  log2(NUM_THREADS)  offered thread id.

Function
REQ-015 Two states: IDLE (fetch_valid=0) and OFFER (fetch_valid=1); fetch_valid, fetch_pc, fetch_tid registered.
REQ-016 Eligible(i) = thread_en[i] & ~stall[i]; selection round-robin, starting at rr_ptr, wrapping from NUM_THREADS-1 to 0.
REQ-017 IDLE -> OFFER next cycle when any thread eligible; offer = first eligible thread at/after rr_ptr, fetch_pc = its current PC.
REQ-018 Issue = fetch_valid & fetch_ready; on issue, PC[fetch_tid] <= PC[fetch_tid]+1 modulo 2^PC_W (all-ones wraps to 0), rr_ptr <= fetch_tid+1 mod NUM_THREADS.
REQ-019 On issue, next cycle presents next eligible thread (back-to-back, one issue per cycle max), else IDLE.
REQ-020 While fetch_valid & ~fetch_ready, fetch_pc/fetch_tid held stable; later stall or thread_en change does not withdraw the offer.
REQ-021 br_valid sets PC[br_tid] <= br_target next cycle, independent of state.
REQ-022 br_valid with br_tid == fetch_tid during OFFER: offer flushed (fetch_valid=0 next cycle, no increment even if fetch_ready), rr_ptr unchanged; thread re-offered later with br_target.
REQ-023 br_valid to a thread other than the offered one: offer and issue proceed normally.
REQ-024 No eligible thread: IDLE, rr_ptr held, PCs held.

Reset
REQ-025 rst_n low: every PC = RESET_PC, rr_ptr = 0, state IDLE, fetch_valid = 0, fetch_pc = RESET_PC, fetch_tid = 0, immediately and asynchronously, including mid-offer.
REQ-026 First offer no earlier than the second rising edge after rst_n deasserts.

Configuration
REQ-027 Macro PC_SCHED_PERF_EN defined: adds output perf_issue_cnt (32 bits), incremented per issue, saturating at all-ones, reset to 0.
REQ-028 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-029 Shared package pc_sched_pkg holds NUM_THREADS/PC_W defaults, tid width constant and state enumeration (IDLE, OFFER).
REQ-030 Sub-module rr_arbiter (request vector + pointer -> one-hot grant, tid, any_grant) is instantiated once; PC increment uses the existing PC_plus_1 unit per thread or inline +1.

Verification
REQ-031 Reset, thread_en=4'b1111, fetch_ready=1 -> tids 0,1,2,3,0 on consecutive cycles, pcs 0,0,0,0,1.
REQ-032 thread_en=4'b0101, fetch_ready=1 -> tids alternate 0,2,0,2; PCs of threads 1,3 stay 0.
REQ-033 Offer tid 1 pc 5, fetch_ready=0 for 3 cycles, stall[1]=1 -> offer held stable; on ready, PC[1] becomes 6.
REQ-034 Offer tid 2, same cycle br_valid, br_tid=2, br_target=64'h100, fetch_ready=1 -> no issue, fetch_valid=0 next cycle, later offer tid 2 pc 64'h100.
REQ-035 Thread 0 PC=64'hFFFF_FFFF_FFFF_FFFF issued -> PC[0]=0; with PC_SCHED_PERF_EN, perf_issue_cnt counts issues exactly.
REQ-036 rst_n pulsed low mid-OFFER -> fetch_valid=0 asynchronously, all PCs RESET_PC, restart from tid 0.
